// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues 1-cycle-latency imem reads and
// queues returned words with their PCs for the decoder. Optional FETCH_BYPASS_EN lets
// a response reach the decoder in the cycle it arrives when the queue is empty.
module instr_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int IW    = 20,
  parameter int AW    = 8
) (
  input  logic          clock,
  input  logic          reset,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_valid,
  input  logic [IW-1:0] imem_data,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_addr,
  output logic          out_valid,
  output logic [IW-1:0] out_instr,
  output logic [AW-1:0] out_pc,
  input  logic          out_ready
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_FETCH,
    ST_STALL
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] req_pc_q, req_pc_d;
  logic          inflight_q, inflight_d;
  logic          squash_q, squash_d;
  logic [PW:0]   wr_ptr_q, wr_ptr_d;
  logic [PW:0]   rd_ptr_q, rd_ptr_d;

  logic [IW-1:0] instr_mem_q [DEPTH];
  logic [AW-1:0] pc_mem_q    [DEPTH];

  logic [PW:0]   count;
  logic [PW:0]   count_d;
  logic          queue_empty;
  logic          queue_full;
  logic          accept;
  logic          byp_active;
  logic          handshake;
  logic          pop;
  logic          push;
  logic          credit_next;

  assign count       = wr_ptr_q - rd_ptr_q;
  assign queue_empty = (count == '0);
  assign queue_full  = (count == (PW+1)'(DEPTH));

  // A response is dropped if a redirect is happening now or happened last cycle.
  assign accept = imem_valid && !redirect && !squash_q;

`ifdef FETCH_BYPASS_EN
  assign byp_active = queue_empty && accept;
`else
  assign byp_active = 1'b0;
`endif

  // Requests only when in FETCH; the state register tracks the credit rule.
  assign imem_req  = (state_q == ST_FETCH) && !redirect;
  assign imem_addr = fetch_pc_q;

  assign out_valid = !queue_empty || byp_active;
  assign out_instr = !queue_empty ? instr_mem_q[rd_ptr_q[PW-1:0]] :
                     byp_active   ? imem_data : '0;
  assign out_pc    = !queue_empty ? pc_mem_q[rd_ptr_q[PW-1:0]] :
                     byp_active   ? req_pc_q : '0;

  assign handshake = out_valid && out_ready;
  assign pop       = handshake && !queue_empty;
  assign push      = accept && !(byp_active && out_ready) && !queue_full;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = imem_req;
    squash_d   = redirect;
    if (redirect) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fetch_pc_d = redirect_addr;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (imem_req) begin
        fetch_pc_d = fetch_pc_q + 1'b1;
        req_pc_d   = fetch_pc_q;
      end
    end
  end

  // Credit for next cycle counts the new occupancy plus the request issued now;
  // a pop now only frees credit once it is reflected in next cycle's count.
  assign count_d     = wr_ptr_d - rd_ptr_d;
  assign credit_next = ({1'b0, count_d} + {{(PW+1){1'b0}}, inflight_d}) < (PW+2)'(DEPTH);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_BOOT:  state_d = ST_FETCH;
      default:  state_d = credit_next ? ST_FETCH : ST_STALL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_BOOT;
      fetch_pc_q <= '0;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      squash_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      squash_q   <= squash_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; entries are only visible through the reset pointers.
  always_ff @(posedge clock) begin
    if (push) begin
      instr_mem_q[wr_ptr_q[PW-1:0]] <= imem_data;
      pc_mem_q[wr_ptr_q[PW-1:0]]    <= req_pc_q;
    end
  end

endmodule
